// File: rtl/round_commit_collector_pkg.sv
// Shared definitions for the repetition sequencer: default sizes, FSM
// state encoding and the index-width helper.
package round_commit_collector_pkg;

    localparam int DEF_NUM_ROUNDS = 16;
    localparam int DEF_WORD_W     = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RELEASE,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Bits needed to address 'value' entries; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/round_commit_collector_commit_buf.sv
// Dual-bank commitment store: one write port filling the Ch and Cv banks for
// a repetition, one read port whose linear index covers all Ch words first
// and then all Cv words.
module commit_buf
    import round_commit_collector_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int RND_W      = clog2(NUM_ROUNDS),
    parameter int IDX_W      = clog2(2 * NUM_ROUNDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [RND_W-1:0]  wr_rnd,
    input  logic [WORD_W-1:0] wr_ch,
    input  logic [WORD_W-1:0] wr_cv,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] ch_buf [NUM_ROUNDS];
    logic [WORD_W-1:0] cv_buf [NUM_ROUNDS];
    logic              rd_is_ch;
    logic [RND_W-1:0]  ch_off;
    logic [RND_W-1:0]  cv_off;

    // Capture both commitments of one repetition together.
    // NOTE: storage arrays carry no reset; every entry is rewritten before
    // it can be read, and a reset on the array would cost a clear of each word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ch_buf[wr_rnd] <= wr_ch;
            cv_buf[wr_rnd] <= wr_cv;
        end
    end

    assign rd_is_ch = (rd_idx < IDX_W'(NUM_ROUNDS));
    assign ch_off   = RND_W'(rd_idx);
    assign cv_off   = RND_W'(rd_idx - IDX_W'(NUM_ROUNDS));
    assign rd_data  = rd_is_ch ? ch_buf[ch_off] : cv_buf[cv_off];

endmodule

// File: rtl/round_commit_collector.sv
// Repetition sequencer: launches the round stage once per repetition,
// buffers each Ch/Cv pair, then streams all Ch words followed by all Cv
// words to the challenge-hash stage over valid/ready.
module round_commit_collector
    import round_commit_collector_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int WORD_W     = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              stap_start,
    output logic [7:0]        stap_t,
    output logic [7:0]        stap_j,
    input  logic              stap_end,
    input  logic [WORD_W-1:0] ch_in,
    input  logic [WORD_W-1:0] cv_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int                RND_W    = clog2(NUM_ROUNDS);
    localparam int                IDX_W    = clog2(2 * NUM_ROUNDS);
    localparam logic [7:0]        LAST_RND = 8'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2 * NUM_ROUNDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        rnd;
    logic [7:0]        rnd_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  rd_idx;
    logic [WORD_W-1:0] rd_data;
    logic              stap_start_nxt;
    logic              out_valid_nxt;
    logic              out_last_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              load_word;
    logic              cap_en;

    assign idx_inc = idx + 1'b1;
    assign stap_t  = rnd;
    assign stap_j  = rnd;

    commit_buf #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .WORD_W     (WORD_W),
        .RND_W      (RND_W),
        .IDX_W      (IDX_W)
    ) u_commit_buf (
        .clk     (clk),
        .wr_en   (cap_en),
        .wr_rnd  (rnd[RND_W-1:0]),
        .wr_ch   (ch_in),
        .wr_cv   (cv_in),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // FSM state register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode for the sequencer.
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        rnd_nxt        = rnd;
        idx_nxt        = idx;
        rd_idx         = idx;
        stap_start_nxt = stap_start;
        out_valid_nxt  = out_valid;
        out_last_nxt   = out_last;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        load_word      = 1'b0;
        cap_en         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt      = ST_LAUNCH;
                    rnd_nxt        = '0;
                    stap_start_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end

            ST_LAUNCH: begin
                if (stap_end) begin
                    cap_en         = 1'b1;
                    stap_start_nxt = 1'b0;
                    state_nxt      = ST_RELEASE;
                end
            end

            // The round stage holds its end flag until start drops; relaunching
            // before it clears would capture the same result twice.
            ST_RELEASE: begin
                if (!stap_end) begin
                    if (rnd == LAST_RND) begin
                        state_nxt     = ST_STREAM;
                        idx_nxt       = '0;
                        rd_idx        = '0;
                        load_word     = 1'b1;
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = 1'b0;
                    end else begin
                        rnd_nxt        = rnd + 8'd1;
                        stap_start_nxt = 1'b1;
                        state_nxt      = ST_LAUNCH;
                    end
                end
            end

            ST_STREAM: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        done_nxt      = 1'b1;
                        busy_nxt      = 1'b0;
                        state_nxt     = ST_DONE;
                    end else begin
                        idx_nxt      = idx_inc;
                        rd_idx       = idx_inc;
                        load_word    = 1'b1;
                        out_last_nxt = (idx_inc == LAST_IDX);
                    end
                end
            end

            ST_DONE: begin
                rnd_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd        <= '0;
            idx        <= '0;
            stap_start <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rnd        <= rnd_nxt;
            idx        <= idx_nxt;
            stap_start <= stap_start_nxt;
            out_valid  <= out_valid_nxt;
            out_last   <= out_last_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            if (load_word) begin
                out_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_round_commit_collector.sv
// Directed bench: a two-repetition instance driven by a behavioural round
// stage, and a single-repetition instance driven step by step.
module tb_round_commit_collector;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         start_a, stap_start_a, stap_end_a, out_valid_a, out_ready_a;
    logic         out_last_a, busy_a, done_a;
    logic [7:0]   stap_t_a, stap_j_a;
    logic [W-1:0] ch_a, cv_a, out_data_a;

    logic         start_b, stap_start_b, stap_end_b, out_valid_b, out_ready_b;
    logic         out_last_b, busy_b, done_b;
    logic [7:0]   stap_t_b, stap_j_b;
    logic [W-1:0] ch_b, cv_b, out_data_b;

    round_commit_collector #(.NUM_ROUNDS(2), .WORD_W(W)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .stap_start (stap_start_a),
        .stap_t     (stap_t_a),
        .stap_j     (stap_j_a),
        .stap_end   (stap_end_a),
        .ch_in      (ch_a),
        .cv_in      (cv_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .out_data   (out_data_a),
        .out_last   (out_last_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    round_commit_collector #(.NUM_ROUNDS(1), .WORD_W(W)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .stap_start (stap_start_b),
        .stap_t     (stap_t_b),
        .stap_j     (stap_j_b),
        .stap_end   (stap_end_b),
        .ch_in      (ch_b),
        .cv_in      (cv_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_data   (out_data_b),
        .out_last   (out_last_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural round stage for instance A: end rises 5 cycles after start,
    // then stays high hold_extra cycles past the drop of start.
    int         hold_extra;
    int         cnt_a;
    int         hold_a;
    logic [7:0] held_t;

    always @(negedge clk) begin
        if (!reset) begin
            stap_end_a <= 1'b0;
            ch_a       <= '0;
            cv_a       <= '0;
            cnt_a      <= 0;
            hold_a     <= 0;
        end else if (!stap_end_a) begin
            if (stap_start_a) begin
                cnt_a <= cnt_a + 1;
                if (cnt_a == 4) begin
                    stap_end_a <= 1'b1;
                    held_t     <= stap_t_a;
                    ch_a       <= 16'h100 + 16'(stap_t_a);
                    cv_a       <= 16'h200 + 16'(stap_t_a);
                    cnt_a      <= 0;
                end
            end else begin
                cnt_a <= 0;
            end
        end else if (!stap_start_a) begin
            check("held_end_no_advance", {55'd0, stap_start_a, stap_t_a}, {55'd0, 1'b0, held_t});
            if (hold_a >= hold_extra) begin
                stap_end_a <= 1'b0;
                hold_a     <= 0;
            end else begin
                hold_a <= hold_a + 1;
            end
        end
    end

    // Observers: launch indices, accepted words, done pulses, valid cycles.
    logic         prev_start_a;
    logic [7:0]   tseq_a [$];
    logic [W-1:0] words_a [$];
    logic         lasts_a [$];
    logic [W-1:0] words_b [$];
    logic         lasts_b [$];
    int           done_cnt_a = 0;
    int           done_cnt_b = 0;
    int           valid_cyc_a = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_start_a <= 1'b0;
        end else begin
            prev_start_a <= stap_start_a;
            if (stap_start_a && !prev_start_a) tseq_a.push_back(stap_t_a);
            if (out_valid_a) valid_cyc_a <= valid_cyc_a + 1;
            if (out_valid_a && out_ready_a) begin
                words_a.push_back(out_data_a);
                lasts_a.push_back(out_last_a);
            end
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            if (out_valid_b && out_ready_b) begin
                words_b.push_back(out_data_b);
                lasts_b.push_back(out_last_b);
            end
            if (done_b) done_cnt_b <= done_cnt_b + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        check("busy_after_start", busy_a, 1'b1);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 400) begin
            tick();
            n++;
        end
        check(tag, done_a, 1'b1);
        tick();
        tick();
    endtask

    task automatic clear_obs_a();
        tseq_a.delete();
        words_a.delete();
        lasts_a.delete();
    endtask

    task automatic check_run_a(input string tag, input int done_base);
        logic [W-1:0] exp_w [4];
        logic         exp_l [4];
        exp_w = '{16'h100, 16'h101, 16'h200, 16'h201};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        check({tag, "_launches"}, 64'(tseq_a.size()), 64'd2);
        if (tseq_a.size() == 2) begin
            check({tag, "_t0"}, 64'(tseq_a[0]), 64'd0);
            check({tag, "_t1"}, 64'(tseq_a[1]), 64'd1);
        end
        check({tag, "_word_count"}, 64'(words_a.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < words_a.size()) begin
                check({tag, "_word"}, 64'(words_a[i]), 64'(exp_w[i]));
                check({tag, "_last"}, 64'(lasts_a[i]), 64'(exp_l[i]));
            end
        end
        check({tag, "_done_pulses"}, 64'(done_cnt_a - done_base), 64'd1);
        check({tag, "_busy_clear"}, busy_a, 1'b0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_stap_start"}, stap_start_a, 1'b0);
        check({tag, "_stap_t"}, 64'(stap_t_a), 64'd0);
        check({tag, "_stap_j"}, 64'(stap_j_a), 64'd0);
        check({tag, "_out_valid"}, out_valid_a, 1'b0);
        check({tag, "_out_data"}, 64'(out_data_a), 64'd0);
        check({tag, "_out_last"}, out_last_a, 1'b0);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_done"}, done_a, 1'b0);
    endtask

    initial begin
        int base;
        int vbase;
        int n;

        reset       = 1'b0;
        start_a     = 1'b0;
        start_b     = 1'b0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        stap_end_b  = 1'b0;
        ch_b        = '0;
        cv_b        = '0;
        hold_extra  = 0;

        repeat (3) tick();
        check_reset_a("reset");
        check("reset_b_valid", out_valid_b, 1'b0);
        check("reset_b_busy", busy_b, 1'b0);
        reset = 1'b1;
        tick();

        // Plain run, ready tied high.
        clear_obs_a();
        base  = done_cnt_a;
        vbase = valid_cyc_a;
        pulse_start_a();
        wait_done_a("run1_done_seen");
        check_run_a("run1", base);
        check("run1_valid_cycles", 64'(valid_cyc_a - vbase), 64'd4);

        // Backpressure on word 1, plus a start pulse during the stream.
        clear_obs_a();
        base        = done_cnt_a;
        out_ready_a = 1'b0;
        pulse_start_a();
        n = 0;
        while (!out_valid_a && n < 400) begin
            tick();
            n++;
        end
        check("bp_valid_seen", out_valid_a, 1'b1);
        check("bp_word0_data", 64'(out_data_a), 64'h100);
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        start_a     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_stall_data", 64'(out_data_a), 64'h101);
            check("bp_stall_valid", out_valid_a, 1'b1);
            check("bp_stall_last", out_last_a, 1'b0);
            tick();
            start_a = 1'b0;
        end
        out_ready_a = 1'b1;
        wait_done_a("run2_done_seen");
        repeat (4) tick();
        check_run_a("run2", base);
        check("run2_no_restart", stap_start_a, 1'b0);

        // Round stage holds its end flag 4 cycles past the drop of start.
        clear_obs_a();
        base       = done_cnt_a;
        hold_extra = 4;
        pulse_start_a();
        wait_done_a("run3_done_seen");
        check_run_a("run3", base);
        hold_extra = 0;

        // Reset during the second launch, then a clean rerun.
        clear_obs_a();
        pulse_start_a();
        n = 0;
        while (!(stap_start_a && stap_t_a == 8'd1) && n < 400) begin
            tick();
            n++;
        end
        check("rst_reached_t1", {stap_start_a, stap_t_a}, {1'b1, 8'd1});
        reset = 1'b0;
        #1;
        check_reset_a("midrst");
        tick();
        reset = 1'b1;
        tick();
        clear_obs_a();
        base = done_cnt_a;
        pulse_start_a();
        wait_done_a("run4_done_seen");
        check_run_a("run4", base);

        // Single-repetition instance.
        words_b.delete();
        lasts_b.delete();
        base    = done_cnt_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!stap_start_b && n < 50) begin
            tick();
            n++;
        end
        check("b_launch", {stap_start_b, stap_t_b, stap_j_b}, {1'b1, 8'd0, 8'd0});
        tick();
        ch_b       = 16'h000A;
        cv_b       = 16'h000B;
        stap_end_b = 1'b1;
        n = 0;
        while (stap_start_b && n < 50) begin
            tick();
            n++;
        end
        check("b_start_dropped", stap_start_b, 1'b0);
        tick();
        stap_end_b = 1'b0;
        ch_b       = '0;
        cv_b       = '0;
        n = 0;
        while (!done_b && n < 50) begin
            tick();
            n++;
        end
        check("b_done_seen", done_b, 1'b1);
        tick();
        tick();
        check("b_word_count", 64'(words_b.size()), 64'd2);
        if (words_b.size() == 2) begin
            check("b_word0", 64'(words_b[0]), 64'hA);
            check("b_last0", 64'(lasts_b[0]), 64'd0);
            check("b_word1", 64'(words_b[1]), 64'hB);
            check("b_last1", 64'(lasts_b[1]), 64'd1);
        end
        check("b_done_pulses", 64'(done_cnt_b - base), 64'd1);
        check("b_busy_clear", busy_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_commit_collector.md
Name: round_commit_collector

Overview:
- Repetition sequencer that sits directly upstream of the per-repetition round stage (stap4).
- Launches that stage once per repetition index t = 0..NUM_ROUNDS-1 and captures each repetition's Ch and Cv commitments into an internal buffer.
- Streams the buffered commitments, all Ch words first and then all Cv words, over a valid/ready interface to the challenge-hash stage.

Parameters:
NUM_ROUNDS, 16, number of repetitions; legal range 1..255.
WORD_W, 256, commitment width (Ch, Cv, out_data).

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse that begins a full run; ignored while busy=1
stap_start  output  1  start level to the round stage; held high until stap_end is seen
stap_t  output  8  current repetition index to the round stage
stap_j  output  8  same value as stap_t
stap_end  input  1  round-stage completion level; stays high until stap_start drops
ch_in  input  WORD_W  Ch for the current repetition; valid while stap_end=1
cv_in  input  WORD_W  Cv for the current repetition; valid while stap_end=1
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word
out_data  output  WORD_W  streamed commitment word
out_last  output  1  high with the final word (index 2*NUM_ROUNDS-1)
busy  output  1  high from the cycle after start until done
done  output  1  single-cycle pulse after the last word is accepted

Behaviour:
- Reset values: stap_start=0, stap_t=0, stap_j=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, FSM in IDLE, counters 0.
- FSM states and transitions:
  - IDLE: on start=1, go to LAUNCH with rnd=0 and busy=1.
  - LAUNCH: stap_start=1, stap_t=stap_j=rnd. When stap_end=1, write ch_in to ch_buf[rnd] and cv_in to cv_buf[rnd] in that same cycle, set stap_start=0, go to RELEASE.
  - RELEASE: wait for stap_end=0. Then, if rnd==NUM_ROUNDS-1, go to STREAM with idx=0; otherwise rnd+=1 and go to LAUNCH.
  - RELEASE is mandatory. The round stage holds its end flag until its start drops, so relaunching early would double-capture.
  - STREAM: out_valid=1. out_data = ch_buf[idx] for idx<NUM_ROUNDS, otherwise cv_buf[idx-NUM_ROUNDS]. out_last = (idx==2*NUM_ROUNDS-1).
    - On out_valid&&out_ready: idx+=1. If that was the last word, set out_valid=0 and go to DONE.
    - While out_valid&&!out_ready, out_data and out_last hold stable.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency:
  - Capture is one cycle after stap_end rises, as seen by stap_start dropping.
  - The first out_valid appears one cycle after the final RELEASE exits.
  - With out_ready tied high, streaming takes exactly 2*NUM_ROUNDS cycles.
- Registered outputs: out_data/out_last are registered. The next word is loaded in the same cycle as the handshake, so back-to-back transfers run at one word per cycle.
- Buffers: two arrays of NUM_ROUNDS x WORD_W. Indices are ceil(log2(2*NUM_ROUNDS)) bits wide; idx never wraps past 2*NUM_ROUNDS-1.
- start is a don't-care in all states except IDLE; a start coinciding with done is ignored.
- Reset mid-operation (any state): immediate return to all reset values. Buffer contents become undefined and are never streamed before being rewritten.
- stap_end=1 while in IDLE or STREAM is ignored.
- NUM_ROUNDS=1: a single LAUNCH/RELEASE pass, then two words with out_last on the second.

Decomposition:
- Shared package:
  - localparams for the default NUM_ROUNDS and WORD_W.
  - The FSM state encoding (IDLE, LAUNCH, RELEASE, STREAM, DONE).
  - The index-width function clog2.
- One sub-module, commit_buf: a dual-bank register file (ch/cv) with one write port (rnd, ch, cv) and one read port (idx). It maps idx to the correct bank.

Test Plan:
- Run with NUM_ROUNDS=2:
  - Stimulus: behavioural round stage returning Ch=0x100+t and Cv=0x200+t after 5 cycles; start pulse; out_ready=1.
  - Required: stap_t sequence 0,1; stream 0x100, 0x101, 0x200, 0x201; out_last only on 0x201; done pulses once.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while word 1 is presented.
  - Required: out_data=0x101 stays stable with out_valid=1; no word skipped or duplicated.
- Held end:
  - Stimulus: round stage keeps stap_end high 4 cycles after stap_start drops.
  - Required: rnd does not advance until stap_end=0; exactly one capture per repetition.
- Reset mid-run:
  - Stimulus: assert reset during LAUNCH of t=1, then start again.
  - Required: all outputs return to 0 immediately; the second run restarts at t=0 and produces the full correct stream.
- Start while busy:
  - Stimulus: second start pulse during STREAM.
  - Required: ignored; exactly 2*NUM_ROUNDS words and one done pulse.
- Edge case NUM_ROUNDS=1:
  - Stimulus: Ch=0xA, Cv=0xB.
  - Required: stream 0xA then 0xB with out_last on 0xB.
